packet_fifo: RTL and testbench

PACKET_FIFO -- requirements
Module: packet_fifo

---
 rtl/packet_fifo_pkg.sv | 17 +
 rtl/packet_fifo_mem.sv | 39 +++
 rtl/packet_fifo.sv | 119 +++++++++++
 tb/tb_packet_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_fifo_pkg.sv
// Shared defaults and operation encoding for the packet FIFO slice.
package packet_fifo_pkg;

  localparam int DEPTH_DEF     = 4;
  localparam int WIDTH_DEF     = 11;
  localparam int UWIDTH_DEF    = 8;
  localparam int PTR_SZ_DEF    = 2;
  localparam int PTR_IN_SZ_DEF = 4;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_BOTH
  } fifo_op_e;

endpackage

// File: rtl/packet_fifo_mem.sv
// Packet storage: DEPTH slots of WIDTH bytes, one write port, combinational read port.
module packet_fifo_mem
  import packet_fifo_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int UWIDTH    = UWIDTH_DEF,
  parameter int PTR_SZ    = PTR_SZ_DEF,
  parameter int PTR_IN_SZ = PTR_IN_SZ_DEF
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 we,
  input  logic [PTR_SZ-1:0]    wslot,
  input  logic [PTR_IN_SZ-1:0] widx,
  input  logic [UWIDTH-1:0]    wdata,
  input  logic [PTR_SZ-1:0]    rslot,
  input  logic [PTR_IN_SZ-1:0] ridx,
  output logic [UWIDTH-1:0]    rdata
);

  logic [UWIDTH-1:0] mem [DEPTH][WIDTH];

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        for (int unsigned b = 0; b < WIDTH; b++) begin
          mem[s][b] <= '0;
        end
      end
    end else if (we) begin
      mem[wslot][widx] <= wdata;
    end
  end

  // Caller is responsible for gating out-of-range indices.
  assign rdata = mem[rslot][ridx];

endmodule

// File: rtl/packet_fifo.sv
// Packet FIFO: bytes are staged into the write slot and made visible only on commit (winc).
// Optional sticky overflow/underflow outputs wovf/rudf are built when PACKET_FIFO_ERR_EN is defined.
module packet_fifo
  import packet_fifo_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int UWIDTH    = UWIDTH_DEF,
  parameter int PTR_SZ    = PTR_SZ_DEF,
  parameter int PTR_IN_SZ = PTR_IN_SZ_DEF
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 winc,
  input  logic [PTR_IN_SZ-1:0] waddr_in,
  input  logic [UWIDTH-1:0]    wdata,
  input  logic                 rinc,
  input  logic [PTR_IN_SZ-1:0] raddr_in,
  output logic [UWIDTH-1:0]    rdata,
  output logic                 wfull,
  output logic                 rempty
`ifdef PACKET_FIFO_ERR_EN
  ,
  output logic                 wovf,
  output logic                 rudf
`endif
);

  localparam logic [PTR_SZ:0]    FULL_CNT  = (PTR_SZ+1)'(DEPTH);
  localparam logic [PTR_SZ-1:0]  LAST_SLOT = PTR_SZ'(DEPTH-1);
  localparam logic [PTR_IN_SZ:0] WIDTH_LIM = (PTR_IN_SZ+1)'(WIDTH);

  logic [PTR_SZ-1:0] wptr;
  logic [PTR_SZ-1:0] rptr;
  logic [PTR_SZ:0]   count;
  logic              push_ok;
  logic              pop_ok;
  logic              we;
  logic              rd_ok;
  logic [UWIDTH-1:0] mem_rdata;
  fifo_op_e          op;

  function automatic logic [PTR_SZ-1:0] bump(input logic [PTR_SZ-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_SZ'(1);
  endfunction

  assign wfull   = (count == FULL_CNT);
  assign rempty  = (count == '0);
  assign push_ok = winc & ~wfull;
  assign pop_ok  = rinc & ~rempty;
  assign we      = ~wfull & ({1'b0, waddr_in} < WIDTH_LIM);
  assign rd_ok   = ~rempty & ({1'b0, raddr_in} < WIDTH_LIM);
  assign rdata   = rd_ok ? mem_rdata : '0;

  always_comb begin
    op = OP_IDLE;
    case ({push_ok, pop_ok})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          wptr  <= bump(wptr);
          count <= count + (PTR_SZ+1)'(1);
        end
        OP_POP: begin
          rptr  <= bump(rptr);
          count <= count - (PTR_SZ+1)'(1);
        end
        OP_BOTH: begin
          wptr <= bump(wptr);
          rptr <= bump(rptr);
        end
        default: ;
      endcase
    end
  end

`ifdef PACKET_FIFO_ERR_EN
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      wovf <= 1'b0;
      rudf <= 1'b0;
    end else begin
      if (winc && wfull)  wovf <= 1'b1;
      if (rinc && rempty) rudf <= 1'b1;
    end
  end
`endif

  packet_fifo_mem #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .UWIDTH    (UWIDTH),
    .PTR_SZ    (PTR_SZ),
    .PTR_IN_SZ (PTR_IN_SZ)
  ) u_mem (
    .clk1  (clk1),
    .rst   (rst),
    .we    (we),
    .wslot (wptr),
    .widx  (waddr_in),
    .wdata (wdata),
    .rslot (rptr),
    .ridx  (raddr_in),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_packet_fifo.sv
// Self-checking bench for packet_fifo: vector table plus scoreboarded multi-cycle sequences.
module tb_packet_fifo;

  localparam int DEPTH = 4;

  logic       clk1 = 1'b0;
  logic       rst = 1'b1;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic [3:0] waddr_in = 4'hF;
  logic [3:0] raddr_in = 4'h0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       wfull;
  logic       rempty;
`ifdef PACKET_FIFO_ERR_EN
  logic       wovf;
  logic       rudf;
`endif

  int checks = 0;
  int errors = 0;
  int mcount = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic       winc;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       rinc;
    logic [3:0] raddr;
    logic       e_empty;
    logic       e_full;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vecs[13];

  packet_fifo dut (
    .clk1     (clk1),
    .rst      (rst),
    .winc     (winc),
    .waddr_in (waddr_in),
    .wdata    (wdata),
    .rinc     (rinc),
    .raddr_in (raddr_in),
    .rdata    (rdata),
    .wfull    (wfull),
    .rempty   (rempty)
`ifdef PACKET_FIFO_ERR_EN
    ,
    .wovf     (wovf),
    .rudf     (rudf)
`endif
  );

  always #5 clk1 = ~clk1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; waddr_in = 4'hF;
    tick();
    rst = 1'b0;
    sb.delete();
    mcount = 0;
  endtask

  task automatic commit(input logic [7:0] b);
    waddr_in = 4'd0; wdata = b; winc = 1'b1; rinc = 1'b0;
    if (mcount < DEPTH) begin
      sb.push_back(b);
      mcount++;
    end
    tick();
    winc = 1'b0; waddr_in = 4'hF;
  endtask

  task automatic pop();
    raddr_in = 4'd0; rinc = 1'b1; winc = 1'b0;
    #2;
    check("pop_rdata", rdata, (sb.size() > 0) ? sb[0] : 8'h00);
    if (mcount > 0) begin
      void'(sb.pop_front());
      mcount--;
    end
    tick();
    rinc = 1'b0;
  endtask

  task automatic both(input logic [7:0] b);
    logic was_full;
    logic was_empty;
    was_full  = (mcount == DEPTH);
    was_empty = (mcount == 0);
    waddr_in = 4'd0; wdata = b; winc = 1'b1; rinc = 1'b1; raddr_in = 4'd0;
    #2;
    check("both_rdata", rdata, was_empty ? 8'h00 : sb[0]);
    if (!was_empty) begin
      void'(sb.pop_front());
      mcount--;
    end
    if (!was_full) begin
      sb.push_back(b);
      mcount++;
    end
    tick();
    winc = 1'b0; rinc = 1'b0; waddr_in = 4'hF;
  endtask

  initial begin
    //             winc waddr wdata  rinc raddr empty full rdata
    vecs[0]  = '{1'b0, 4'd0,  8'd10,  1'b0, 4'd0, 1'b1, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 4'd1,  8'd160, 1'b0, 4'd0, 1'b1, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 4'd2,  8'd3,   1'b0, 4'd0, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 4'd3,  8'd0,   1'b0, 4'd0, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 4'd4,  8'd1,   1'b0, 4'd0, 1'b1, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 4'd5,  8'd2,   1'b0, 4'd0, 1'b1, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 4'd6,  8'd15,  1'b0, 4'd0, 1'b1, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 4'd15, 8'd0,   1'b0, 4'd0, 1'b0, 1'b0, 8'd10};
    vecs[8]  = '{1'b0, 4'd15, 8'd0,   1'b0, 4'd6, 1'b0, 1'b0, 8'd15};
    vecs[9]  = '{1'b0, 4'd15, 8'd0,   1'b0, 4'd1, 1'b0, 1'b0, 8'd160};
    vecs[10] = '{1'b0, 4'd15, 8'd0,   1'b0, 4'd11, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{1'b0, 4'd15, 8'd0,   1'b1, 4'd2, 1'b0, 1'b0, 8'd3};
    vecs[12] = '{1'b0, 4'd15, 8'd0,   1'b0, 4'd2, 1'b1, 1'b0, 8'd0};

    // Reset state with rst held across clock edges.
    repeat (2) @(posedge clk1);
    #1;
    check("reset_rempty", rempty, 1);
    check("reset_wfull", wfull, 0);
    check("reset_rdata", rdata, 0);
`ifdef PACKET_FIFO_ERR_EN
    check("reset_wovf", wovf, 0);
    check("reset_rudf", rudf, 0);
`endif
    rst = 1'b0;

    // Single packet staged then committed on its last byte.
    for (int i = 0; i < 13; i++) begin
      winc = vecs[i].winc; waddr_in = vecs[i].waddr; wdata = vecs[i].wdata;
      rinc = vecs[i].rinc; raddr_in = vecs[i].raddr;
      #2;
      check($sformatf("vec%0d_rempty", i), rempty, vecs[i].e_empty);
      check($sformatf("vec%0d_wfull", i), wfull, vecs[i].e_full);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].e_rdata);
      @(posedge clk1);
      #1;
    end
    winc = 1'b0; rinc = 1'b0;

    // Fill to full, overflow attempt, drain in order, underflow attempt.
    do_reset();
    commit(8'd10); commit(8'd100); commit(8'd255); commit(8'd63);
    check("fill_wfull", wfull, 1);
    check("fill_count", dut.count, mcount);
    commit(8'd77);
    check("ovf_wfull", wfull, 1);
    check("ovf_count", dut.count, mcount);
`ifdef PACKET_FIFO_ERR_EN
    check("ovf_wovf", wovf, 1);
`endif
    repeat (4) pop();
    check("drain_rempty", rempty, 1);
    pop();
    check("udf_count", dut.count, 0);
    check("udf_rempty", rempty, 1);
`ifdef PACKET_FIFO_ERR_EN
    check("udf_rudf", rudf, 1);
    repeat (3) tick();
    check("udf_rudf_sticky", rudf, 1);
`endif

    // Simultaneous commit and pop at full, empty and partial occupancy.
    do_reset();
`ifdef PACKET_FIFO_ERR_EN
    check("rst_rudf_clear", rudf, 0);
    check("rst_wovf_clear", wovf, 0);
`endif
    commit(8'd1); commit(8'd2); commit(8'd3); commit(8'd4);
    both(8'd5);
    check("both_full_count", dut.count, 3);
    check("both_full_wfull", wfull, 0);
    repeat (3) pop();
    check("both_pre_empty", rempty, 1);
    both(8'd42);
    check("both_empty_count", dut.count, 1);
    check("both_empty_rempty", rempty, 0);
    both(8'd55);
    check("both_mid_count", dut.count, 1);
    pop();
    check("both_mid_drained", rempty, 1);

    // Asynchronous reset mid-cycle discards stored packets immediately.
    do_reset();
    commit(8'd7); commit(8'd8);
    check("arst_pre_rempty", rempty, 0);
    raddr_in = 4'd0;
    rst = 1'b1;
    #1;
    check("arst_rempty", rempty, 1);
    check("arst_wfull", wfull, 0);
    check("arst_rdata", rdata, 0);
    @(posedge clk1);
    #1;
    rst = 1'b0;
    sb.delete();
    mcount = 0;
    waddr_in = 4'hF; winc = 1'b1;
    sb.push_back(8'd0);
    mcount++;
    tick();
    winc = 1'b0;
    check("arst_mem_cleared", rdata, 0);
    pop();

    // Out-of-range write index leaves the staged slot untouched.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      waddr_in = 4'(i); wdata = 8'h30 + 8'(i);
      tick();
    end
    waddr_in = 4'd11; wdata = 8'hAA; winc = 1'b1;
    tick();
    winc = 1'b0; waddr_in = 4'hF;
    for (int i = 0; i < 16; i++) begin
      raddr_in = 4'(i);
      #2;
      check($sformatf("oob_idx%0d", i), rdata, (i < 11) ? (8'h30 + 8'(i)) : 8'h00);
      @(posedge clk1);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
